pic_cmd_sequencer: RTL
======================

Name: pic_cmd_sequencer

Overview:
Clocked, parametrised command front end for the PIC.
- Samples the CPU bus strobes synchronously.
- Steps through the ICW1..ICW4 initialisation sequence with a state machine, then decodes OCW1..OCW3.
- Returns IMR, IRR or ISR on the data bus, as selected by OCW3.
- Sits between the CPU bus pins and the PIC control logic / priority resolver.

Parameters:
DATA_W, 8, width of bus data and all ICW/OCW registers (minimum 8)
IRQ_N, 8, number of interrupt lines on irr_i/isr_i (1..DATA_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs_n  in  1  chip select, active low
rd_n  in  1  read strobe, active low
wr_n  in  1  write strobe, active low
a0  in  1  address bit 0
din  in  DATA_W  write data
irr_i  in  IRQ_N  interrupt request register from control logic
isr_i  in  IRQ_N  in-service register from control logic
dout  out  DATA_W  read data
dout_en  out  1  drive enable for bus data
icw1, icw2, icw3, icw4  out  DATA_W each  initialisation words
ocw1, ocw2, ocw3  out  DATA_W each  operation words (ocw1 = IMR)
init_done  out  1  initialisation sequence complete
ocw2_stb  out  1  one-cycle pulse when ocw2 is written
ocw3_stb  out  1  one-cycle pulse when ocw3 is written
poll_ack  out  1  poll word returned (PIC_POLL_EN only; tied 0 otherwise)

Behaviour:
- Reset: state IDLE; all ICW/OCW registers 0; dout=0; dout_en=0; init_done=0; strobes 0; read select = IRR; wr_n_q=1.
- Write event: sampled wr_n_q==1 && wr_n==0 && cs_n==0; din and a0 are captured in that cycle.
  - Registers update at the next clk edge (1-cycle latency); stb pulses are coincident with the register update.
  - Holding wr_n low produces no further events.
- ICW1 detect: a0==0 && din[4]==1, valid in any state.
  - Loads icw1; clears icw2..icw4, ocw1 and ocw3; read select = IRR; init_done=0; state -> WAIT_ICW2.
- FSM:
  - IDLE: only ICW1 is accepted; all other writes are ignored.
  - WAIT_ICW2: a0==1 loads icw2. Next state: WAIT_ICW3 if icw1[1]==0; else WAIT_ICW4 if icw1[0]==1; else READY.
  - WAIT_ICW3: a0==1 loads icw3. Next state: WAIT_ICW4 if icw1[0]==1, else READY.
  - WAIT_ICW4: a0==1 loads icw4 -> READY.
  - In any WAIT state, a0==0 with din[4]==0 is ignored.
  - Entering READY sets init_done=1. icw4 stays 0 if it was skipped.
  - READY decode:
    - a0==1: ocw1.
    - a0==0, din[4:3]==00: ocw2 + ocw2_stb.
    - a0==0, din[4:3]==01: ocw3 + ocw3_stb.
    - If din[1]==1, read select = din[0] (0=IRR, 1=ISR); din[1]==0 leaves it unchanged.
- Read:
  - Active while cs_n==0 && rd_n==0, sampled each cycle; dout/dout_en are registered (1-cycle latency).
  - dout = ocw1 if a0==1; otherwise IRR or ISR per read select, zero-extended from IRQ_N to DATA_W.
  - dout tracks irr_i/isr_i each cycle while the read is held.
  - dout_en drops 1 cycle after rd_n or cs_n goes high; dout then holds its last value.
  - Reads are allowed in any state.
- Simultaneous rd_n==0 and wr_n==0 with cs_n==0: the write is processed and the read is suppressed (dout_en=0).
- Reset mid-sequence or mid-read returns to the full reset state on the next edge.

Optional Feature:
PIC_POLL_EN
- With the macro: an OCW3 write in READY with din[2]==1 sets poll_pending.
- The next read event (first cycle of an active read) returns the poll word regardless of a0 and pulses poll_ack for 1 cycle. poll_pending then clears.
- Poll word: bit DATA_W-1 = |(irr_i & ~ocw1[IRQ_N-1:0]); low clog2(IRQ_N) bits = index of the lowest-numbered set bit of that masked vector (0 if none); all other bits 0.
- ICW1 or reset clears poll_pending.
- Without the macro: din[2] is ignored; poll_ack=0.

Test Plan:
- Reset, then write ICW1=0x13 (single, IC4), ICW2=0x20, ICW4=0x01 -> icw3=0x00, icw4=0x01, init_done=1 one cycle after the third write.
- ICW1=0x11 (cascade, IC4), ICW2=0x40, ICW3=0x04, ICW4=0x03 -> all four registers loaded; init_done rises only after ICW4.
- After init: a0=1 write 0xF0 -> ocw1=0xF0; a0=0 0x20 -> ocw2=0x20 with ocw2_stb 1 cycle; a0=0 0x0B -> ocw3=0x0B and read select = ISR.
- Read with a0=0, isr_i=0x08 -> dout=0x08, dout_en=1 a cycle after rd_n falls. Write OCW3 0x0A, irr_i=0x81 -> dout=0x81. Read with a0=1 -> dout=0xF0.
- Mid-sequence (after ICW2) write ICW1=0x13 -> restart at WAIT_ICW2. Assert reset mid-read -> dout_en=0, all registers 0 next edge.
- PIC_POLL_EN: ocw1=0x00, irr_i=0x24, write OCW3=0x0C, then read -> dout=0x82, poll_ack pulse. Second read returns IRR=0x24.

Source files
------------

// File: rtl/pic_cmd_sequencer_if.sv
// CPU-side bus of the PIC command sequencer: strobes, address bit, write and read data.
interface pic_cmd_sequencer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              a0;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_en;

    modport master (
        output cs_n, rd_n, wr_n, a0, din,
        input  dout, dout_en
    );

    modport slave (
        input  cs_n, rd_n, wr_n, a0, din,
        output dout, dout_en
    );
endinterface

// File: rtl/pic_cmd_sequencer.sv
// PIC command front end: ICW1..ICW4 init sequence, OCW1..OCW3 decode, IMR/IRR/ISR readback.
// Optional poll command support is enabled with `define PIC_POLL_EN.
module pic_cmd_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IRQ_N  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pic_cmd_sequencer_if.slave   io_bus,
    input  logic [IRQ_N-1:0]     i_irr,
    input  logic [IRQ_N-1:0]     i_isr,
    output logic [DATA_W-1:0]    o_icw1,
    output logic [DATA_W-1:0]    o_icw2,
    output logic [DATA_W-1:0]    o_icw3,
    output logic [DATA_W-1:0]    o_icw4,
    output logic [DATA_W-1:0]    o_ocw1,
    output logic [DATA_W-1:0]    o_ocw2,
    output logic [DATA_W-1:0]    o_ocw3,
    output logic                 o_init_done,
    output logic                 o_ocw2_stb,
    output logic                 o_ocw3_stb,
    output logic                 o_poll_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ICW2,
        S_WAIT_ICW3,
        S_WAIT_ICW4,
        S_READY
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_wr_n_q;
    logic [DATA_W-1:0] r_icw1, r_icw2, r_icw3, r_icw4;
    logic [DATA_W-1:0] r_ocw1, r_ocw2, r_ocw3;
    logic [DATA_W-1:0] w_icw1_nxt, w_icw2_nxt, w_icw3_nxt, w_icw4_nxt;
    logic [DATA_W-1:0] w_ocw1_nxt, w_ocw2_nxt, w_ocw3_nxt;
    logic              r_init_done, w_init_done_nxt;
    logic              r_ocw2_stb, w_ocw2_stb_nxt;
    logic              r_ocw3_stb, w_ocw3_stb_nxt;
    logic              r_rd_sel_isr, w_rd_sel_isr_nxt;
    logic [DATA_W-1:0] r_dout, w_dout_nxt;
    logic              r_dout_en, w_dout_en_nxt;

    logic w_wr_evt;
    logic w_rd_act;

    // A falling wr_n under chip select is one write; a write cycle masks any read.
    assign w_wr_evt = r_wr_n_q && !io_bus.wr_n && !io_bus.cs_n;
    assign w_rd_act = !io_bus.cs_n && !io_bus.rd_n && io_bus.wr_n;

`ifdef PIC_POLL_EN
    localparam int unsigned IDX_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

    logic              r_poll_pending, w_poll_pending_nxt;
    logic              r_poll_ack, w_poll_ack_nxt;
    logic              r_rd_act_q;
    logic [IRQ_N-1:0]  w_masked;
    logic [IDX_W-1:0]  w_poll_idx;
    logic [DATA_W-1:0] w_poll_word;

    assign w_masked = i_irr & ~r_ocw1[IRQ_N-1:0];

    // Lowest-numbered unmasked request wins.
    always_comb begin
        w_poll_idx = '0;
        for (int i = int'(IRQ_N) - 1; i >= 0; i--) begin
            if (w_masked[i]) w_poll_idx = IDX_W'(i);
        end
        w_poll_word                = '0;
        w_poll_word[IDX_W-1:0]     = w_poll_idx;
        w_poll_word[DATA_W-1]      = |w_masked;
    end
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_icw1_nxt       = r_icw1;
        w_icw2_nxt       = r_icw2;
        w_icw3_nxt       = r_icw3;
        w_icw4_nxt       = r_icw4;
        w_ocw1_nxt       = r_ocw1;
        w_ocw2_nxt       = r_ocw2;
        w_ocw3_nxt       = r_ocw3;
        w_init_done_nxt  = r_init_done;
        w_ocw2_stb_nxt   = 1'b0;
        w_ocw3_stb_nxt   = 1'b0;
        w_rd_sel_isr_nxt = r_rd_sel_isr;
        w_dout_nxt       = r_dout;
        w_dout_en_nxt    = 1'b0;
`ifdef PIC_POLL_EN
        w_poll_pending_nxt = r_poll_pending;
        w_poll_ack_nxt     = 1'b0;
`endif

        if (w_wr_evt) begin
            if (!io_bus.a0 && io_bus.din[4]) begin
                // ICW1 restarts initialisation from any state.
                w_icw1_nxt       = io_bus.din;
                w_icw2_nxt       = '0;
                w_icw3_nxt       = '0;
                w_icw4_nxt       = '0;
                w_ocw1_nxt       = '0;
                w_ocw3_nxt       = '0;
                w_rd_sel_isr_nxt = 1'b0;
                w_init_done_nxt  = 1'b0;
                w_state_nxt      = S_WAIT_ICW2;
`ifdef PIC_POLL_EN
                w_poll_pending_nxt = 1'b0;
`endif
            end else begin
                case (r_state)
                    S_WAIT_ICW2: if (io_bus.a0) begin
                        w_icw2_nxt = io_bus.din;
                        if (!r_icw1[1]) begin
                            w_state_nxt = S_WAIT_ICW3;
                        end else if (r_icw1[0]) begin
                            w_state_nxt = S_WAIT_ICW4;
                        end else begin
                            w_state_nxt     = S_READY;
                            w_init_done_nxt = 1'b1;
                        end
                    end
                    S_WAIT_ICW3: if (io_bus.a0) begin
                        w_icw3_nxt = io_bus.din;
                        if (r_icw1[0]) begin
                            w_state_nxt = S_WAIT_ICW4;
                        end else begin
                            w_state_nxt     = S_READY;
                            w_init_done_nxt = 1'b1;
                        end
                    end
                    S_WAIT_ICW4: if (io_bus.a0) begin
                        w_icw4_nxt      = io_bus.din;
                        w_state_nxt     = S_READY;
                        w_init_done_nxt = 1'b1;
                    end
                    S_READY: begin
                        if (io_bus.a0) begin
                            w_ocw1_nxt = io_bus.din;
                        end else if (!io_bus.din[3]) begin
                            w_ocw2_nxt     = io_bus.din;
                            w_ocw2_stb_nxt = 1'b1;
                        end else begin
                            w_ocw3_nxt     = io_bus.din;
                            w_ocw3_stb_nxt = 1'b1;
                            if (io_bus.din[1]) w_rd_sel_isr_nxt = io_bus.din[0];
`ifdef PIC_POLL_EN
                            if (io_bus.din[2]) w_poll_pending_nxt = 1'b1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (w_rd_act) begin
            w_dout_en_nxt = 1'b1;
            if (io_bus.a0)         w_dout_nxt = r_ocw1;
            else if (r_rd_sel_isr) w_dout_nxt = DATA_W'(i_isr);
            else                   w_dout_nxt = DATA_W'(i_irr);
`ifdef PIC_POLL_EN
            // First cycle of a read after a poll command returns the poll word.
            if (r_poll_pending && !r_rd_act_q) begin
                w_dout_nxt         = w_poll_word;
                w_poll_ack_nxt     = 1'b1;
                w_poll_pending_nxt = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_wr_n_q     <= 1'b1;
            r_icw1       <= '0;
            r_icw2       <= '0;
            r_icw3       <= '0;
            r_icw4       <= '0;
            r_ocw1       <= '0;
            r_ocw2       <= '0;
            r_ocw3       <= '0;
            r_init_done  <= 1'b0;
            r_ocw2_stb   <= 1'b0;
            r_ocw3_stb   <= 1'b0;
            r_rd_sel_isr <= 1'b0;
            r_dout       <= '0;
            r_dout_en    <= 1'b0;
`ifdef PIC_POLL_EN
            r_poll_pending <= 1'b0;
            r_poll_ack     <= 1'b0;
            r_rd_act_q     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_wr_n_q     <= io_bus.wr_n;
            r_icw1       <= w_icw1_nxt;
            r_icw2       <= w_icw2_nxt;
            r_icw3       <= w_icw3_nxt;
            r_icw4       <= w_icw4_nxt;
            r_ocw1       <= w_ocw1_nxt;
            r_ocw2       <= w_ocw2_nxt;
            r_ocw3       <= w_ocw3_nxt;
            r_init_done  <= w_init_done_nxt;
            r_ocw2_stb   <= w_ocw2_stb_nxt;
            r_ocw3_stb   <= w_ocw3_stb_nxt;
            r_rd_sel_isr <= w_rd_sel_isr_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_en    <= w_dout_en_nxt;
`ifdef PIC_POLL_EN
            r_poll_pending <= w_poll_pending_nxt;
            r_poll_ack     <= w_poll_ack_nxt;
            r_rd_act_q     <= w_rd_act;
`endif
        end
    end

    assign o_icw1         = r_icw1;
    assign o_icw2         = r_icw2;
    assign o_icw3         = r_icw3;
    assign o_icw4         = r_icw4;
    assign o_ocw1         = r_ocw1;
    assign o_ocw2         = r_ocw2;
    assign o_ocw3         = r_ocw3;
    assign o_init_done    = r_init_done;
    assign o_ocw2_stb     = r_ocw2_stb;
    assign o_ocw3_stb     = r_ocw3_stb;
    assign io_bus.dout    = r_dout;
    assign io_bus.dout_en = r_dout_en;
`ifdef PIC_POLL_EN
    assign o_poll_ack     = r_poll_ack;
`else
    assign o_poll_ack     = 1'b0;
`endif

endmodule
